// File: rtl/io_pkg.sv
// ============================================================================
//  Module      : io_pkg
//  Description : Shared constants and read-select encoding for the board I/O.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package io_pkg;

  localparam int N_BTN   = 5;
  localparam int N_SW    = 16;
  localparam int N_IN    = N_BTN + N_SW;
  localparam int RD_W    = 16;

  // Button-word field offsets
  localparam int EVT_LSB = 0;
  localparam int LVL_LSB = 8;

  typedef enum logic {
    RD_SEL_SW  = 1'b0,
    RD_SEL_BTN = 1'b1
  } rd_sel_e;

endpackage

`default_nettype wire

// File: rtl/debounce_bit.sv
// ============================================================================
//  Module      : debounce_bit
//  Description : Two-flop synchronizer plus tick-qualified debounce for one bit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_bit #(
  parameter int STABLE_TICKS = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic raw,
  output logic level
);

  localparam int c_cnt_w = $clog2(STABLE_TICKS + 1);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(STABLE_TICKS - 1);

  logic               r_sync1;
  logic               r_sync2;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_stable;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
      // A return to the stable level before qualifying restarts the count
      if (tick) begin
        if (r_sync2 != r_stable) begin
          if (r_cnt == c_last) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end else begin
          r_cnt <= '0;
        end
      end
    end
  end

  assign level = r_stable;

endmodule

`default_nettype wire

// File: rtl/input_debouncer.sv
// ============================================================================
//  Module      : input_debouncer
//  Description : Debounced buttons/switches with sticky press events and a
//                registered CPU read port (button reads clear returned events).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module input_debouncer
  import io_pkg::*;
#(
  parameter int TICK_CYCLES  = 100000,
  parameter int STABLE_TICKS = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_BTN-1:0]  buttons_raw,
  input  logic [N_SW-1:0]   switches_raw,
  input  logic              rd_en,
  input  logic              rd_sel,
  output logic [RD_W-1:0]   rd_data,
  output logic              rd_valid,
  output logic [N_BTN-1:0]  btn_level,
  output logic [N_SW-1:0]   sw_level,
  output logic [N_BTN-1:0]  btn_press,
  output logic              event_pending
);

  localparam int c_pre_w = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(TICK_CYCLES - 1);

  logic [c_pre_w-1:0] r_pre;
  logic               w_tick;
  logic [N_IN-1:0]    w_raw;
  logic [N_IN-1:0]    w_level;
  logic [N_BTN-1:0]   r_btn_prev;
  logic [N_BTN-1:0]   r_btn_press;
  logic [N_BTN-1:0]   r_evt;
  logic [N_BTN-1:0]   w_rise;
  logic [N_BTN-1:0]   w_evt_clr;
  logic               w_rd_btn;
  logic [RD_W-1:0]    w_btn_word;
  logic [RD_W-1:0]    w_rd_word;
  logic [RD_W-1:0]    r_rd_data;
  logic               r_rd_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pre <= '0;
    end else if (r_pre == c_pre_last) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  assign w_tick = (r_pre == c_pre_last);
  assign w_raw  = {switches_raw, buttons_raw};

  for (genvar i = 0; i < N_IN; i++) begin : g_bit
    debounce_bit #(
      .STABLE_TICKS (STABLE_TICKS)
    ) u_debounce_bit (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (w_tick),
      .raw     (w_raw[i]),
      .level   (w_level[i])
    );
  end

  assign btn_level = w_level[N_BTN-1:0];
  assign sw_level  = w_level[N_IN-1:N_BTN];

  // Only the bits actually returned are cleared, so a press landing on the
  // same edge as the read survives
  assign w_rise    = btn_level & ~r_btn_prev;
  assign w_rd_btn  = rd_en && (rd_sel == RD_SEL_BTN);
  assign w_evt_clr = w_rd_btn ? r_evt : '0;

  always_comb begin
    w_btn_word                     = '0;
    w_btn_word[LVL_LSB +: N_BTN]   = btn_level;
    w_btn_word[EVT_LSB +: N_BTN]   = r_evt;
  end

  assign w_rd_word = (rd_sel == RD_SEL_BTN) ? w_btn_word : sw_level;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_btn_prev  <= '0;
      r_btn_press <= '0;
      r_evt       <= '0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
    end else begin
      r_btn_prev  <= btn_level;
      r_btn_press <= w_rise;
      r_evt       <= (r_evt & ~w_evt_clr) | w_rise;
      r_rd_valid  <= rd_en;
      if (rd_en) begin
        r_rd_data <= w_rd_word;
      end
    end
  end

  assign btn_press     = r_btn_press;
  assign rd_data       = r_rd_data;
  assign rd_valid      = r_rd_valid;
  assign event_pending = |r_evt;

endmodule

`default_nettype wire

// File: tb/tb_input_debouncer.sv
// ============================================================================
//  Module      : tb_input_debouncer
//  Description : Self-checking bench for input_debouncer (TICK=4, STABLE=3).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_input_debouncer;

  logic        clk;
  logic        reset_n;
  logic [4:0]  buttons_raw;
  logic [15:0] switches_raw;
  logic        rd_en;
  logic        rd_sel;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic [4:0]  btn_level;
  logic [15:0] sw_level;
  logic [4:0]  btn_press;
  logic        event_pending;

  input_debouncer #(
    .TICK_CYCLES  (4),
    .STABLE_TICKS (3)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .buttons_raw   (buttons_raw),
    .switches_raw  (switches_raw),
    .rd_en         (rd_en),
    .rd_sel        (rd_sel),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .btn_level     (btn_level),
    .sw_level      (sw_level),
    .btn_press     (btn_press),
    .event_pending (event_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] data;
  } rd_exp_t;

  typedef struct {
    logic [15:0] sw;
    logic [15:0] exp_rd;
  } sw_vec_t;

  rd_exp_t q[$];
  sw_vec_t tbl[5];
  int      n_cmp = 0;
  int      n_err = 0;
  int      pc[5];
  int      cyc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic clear_pc();
    for (int i = 0; i < 5; i++) pc[i] = 0;
  endtask

  // One clock: sample at the falling edge, retire any returned read
  task automatic step();
    rd_exp_t e;
    @(negedge clk);
    for (int i = 0; i < 5; i++) if (btn_press[i]) pc[i]++;
    if (rd_valid) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rd_valid_unexpected: got rd_valid=1 data=0x%0h, expected no read", rd_data);
      end else begin
        e = q.pop_front();
        chk(e.name, rd_data, e.data);
      end
    end
  endtask

  task automatic rd(input logic sel, input logic [15:0] exp, input string nm);
    rd_en  = 1'b1;
    rd_sel = sel;
    q.push_back('{nm, exp});
    step();
    rd_en  = 1'b0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_rd_data"},   rd_data,       0);
    chk({nm, "_rd_valid"},  rd_valid,      0);
    chk({nm, "_btn_level"}, btn_level,     0);
    chk({nm, "_sw_level"},  sw_level,      0);
    chk({nm, "_btn_press"}, btn_press,     0);
    chk({nm, "_evt_pend"},  event_pending, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{16'hA5C3, 16'hA5C3};
    tbl[1] = '{16'h0000, 16'h0000};
    tbl[2] = '{16'hFFFF, 16'hFFFF};
    tbl[3] = '{16'h1234, 16'h1234};
    tbl[4] = '{16'h8001, 16'h8001};

    reset_n      = 1'b0;
    buttons_raw  = 5'h1F;
    switches_raw = 16'hFFFF;
    rd_en        = 1'b0;
    rd_sel       = 1'b0;

    // Reset with all raw inputs high
    repeat (3) step();
    chk_all_zero("reset");
    clear_pc();
    reset_n = 1'b1;
    cyc = 0;
    while (btn_level !== 5'h1F && cyc < 40) begin step(); cyc++; end
    chk("reset_rise_cycles", cyc, 12);
    chk("reset_sw_level", sw_level, 16'hFFFF);
    repeat (4) step();
    for (int i = 0; i < 5; i++) chk($sformatf("reset_press_count_%0d", i), pc[i], 1);
    chk("reset_evt_pending", event_pending, 1);
    rd(1'b1, 16'h1F1F, "rd_btn_all_events");
    chk("reset_evt_cleared", event_pending, 0);
    rd(1'b1, 16'h1F00, "rd_btn_after_clear");

    // Release everything: falling edges give no pulses
    buttons_raw  = 5'h00;
    switches_raw = 16'h0000;
    clear_pc();
    repeat (20) step();
    chk("fall_btn_level", btn_level, 0);
    chk("fall_sw_level", sw_level, 0);
    chk("fall_press_total", pc[0] + pc[1] + pc[2] + pc[3] + pc[4], 0);
    rd(1'b1, 16'h0000, "rd_btn_idle");

    // Switch word reads
    for (int k = 0; k < 5; k++) begin
      switches_raw = tbl[k].sw;
      repeat (20) step();
      chk($sformatf("sw_level_%0d", k), sw_level, tbl[k].exp_rd);
      rd(1'b0, tbl[k].exp_rd, $sformatf("rd_sw_%0d", k));
      chk($sformatf("sw_rd_evt_%0d", k), event_pending, 0);
    end

    // Clean press on button 2
    buttons_raw = 5'b00100;
    clear_pc();
    cyc = 0;
    while (btn_level[2] !== 1'b1 && cyc < 30) begin step(); cyc++; end
    chk("clean_latency_in_range", (cyc >= 9 && cyc <= 14), 1);
    step();
    chk("clean_press_pulse", btn_press, 5'b00100);
    step();
    chk("clean_press_done", btn_press, 5'b00000);
    chk("clean_evt_pending", event_pending, 1);
    rd(1'b1, 16'h0404, "rd_btn_clean");
    chk("clean_evt_cleared", event_pending, 0);

    // Five-cycle glitch on button 0
    clear_pc();
    buttons_raw = 5'b00101;
    repeat (5) step();
    buttons_raw = 5'b00100;
    repeat (20) step();
    chk("glitch_level", btn_level, 5'b00100);
    chk("glitch_evt", event_pending, 0);
    chk("glitch_press", pc[0], 0);

    // Clearing read on the edge that raises btn_press[1]
    buttons_raw = 5'b00110;
    cyc = 0;
    while (btn_level[1] !== 1'b1 && cyc < 30) begin step(); cyc++; end
    rd_en  = 1'b1;
    rd_sel = 1'b1;
    q.push_back('{"rd_btn_race", 16'h0600});
    step();
    rd_en = 1'b0;
    chk("race_press", btn_press, 5'b00010);
    chk("race_evt_kept", event_pending, 1);
    rd(1'b1, 16'h0602, "rd_btn_after_race");
    chk("race_evt_cleared", event_pending, 0);

    // Back-to-back reads
    rd_en  = 1'b1;
    rd_sel = 1'b1;
    q.push_back('{"rd_b2b_btn", 16'h0600});
    step();
    rd_sel = 1'b0;
    q.push_back('{"rd_b2b_sw", 16'h8001});
    step();
    rd_en = 1'b0;
    step();
    step();
    chk("b2b_queue_drained", q.size(), 0);

    // Asynchronous reset, then reset mid-debounce at count 2
    buttons_raw  = 5'b01000;
    switches_raw = 16'h0000;
    step();
    reset_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    step();
    step();
    reset_n = 1'b1;
    clear_pc();
    repeat (9) step();
    reset_n = 1'b0;
    #1;
    chk("mid_reset_level", btn_level, 0);
    step();
    step();
    reset_n = 1'b1;
    cyc = 0;
    while (btn_level[3] !== 1'b1 && cyc < 40) begin step(); cyc++; end
    chk("mid_reset_requalify", cyc, 12);
    chk("mid_reset_no_pulse", pc[0] + pc[1] + pc[2] + pc[3] + pc[4], 0);
    step();
    chk("mid_reset_press", btn_press, 5'b01000);

    chk("final_queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
